johnson_seq_ctrl: RTL and testbench
===================================

Name: johnson_seq_ctrl

Overview:
- Sequencer that owns a Johnson (twisted-ring) counter and runs it for a programmed number of full rounds, then stops cleanly at the all-zero code.
- Used as a multi-phase enable/strobe generator: a requester issues start/stop, and downstream logic consumes q and phase_idx.
- Adds start/stop/hold control, round counting, direction select and a done pulse around the bare shift ring.

Parameters:
- N, 4, Johnson ring width; sequence length is 2N states (N >= 2).
- RW, 8, width of the rounds and rounds_left fields.
- PW, $clog2(2*N), width of phase_idx (3 for N=4).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  level-sampled request to begin a run; honoured only in IDLE.
- rounds  input  RW  number of full 2N-state rounds; sampled with start.
- dir  input  1  1 = forward (shift left, q[0] <= ~q[N-1]); 0 = reverse (shift right, q[N-1] <= ~q[0]); sampled with start.
- hold  input  1  freezes the ring and counters while in RUN.
- stop  input  1  aborts a run.
- q  output  N  Johnson ring value.
- phase_idx  output  PW  index of the current code, 0..2N-1.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on normal completion.
- rounds_left  output  RW  rounds remaining, including the current round.

Behaviour:
- Reset (synchronous, on an edge with reset=1): state=IDLE, q=0, phase_idx=0, busy=0, done=0, rounds_left=0, latched dir=1. Reset overrides every other input. Reset mid-run drops to IDLE with no done pulse.
- States: IDLE, RUN, DONE.
- IDLE, start=1, rounds!=0: next cycle RUN, q=0, phase_idx=0, rounds_left=rounds, dir latched, busy=1.
- IDLE, start=1, rounds==0: go to DONE (q stays 0, busy stays 0), so done pulses for one cycle.
- RUN, stop=1: next cycle IDLE, q=0, phase_idx=0, rounds_left=0, busy=0, no done. stop beats hold.
- RUN, hold=1, stop=0: q, phase_idx and rounds_left hold their values; busy stays 1.
- RUN, hold=0, stop=0: ring advances one step per cycle in the latched direction.
  - Forward: phase_idx increments mod 2N.
  - Reverse: phase_idx decrements mod 2N. The reverse sequence from 0 is 1000,1100,1110,1111,0111,0011,0001, with phase_idx 7,6,...,1.
- Round boundary: reached on the step that returns q to 0 (phase_idx wraps to 0).
  - If rounds_left==1: go to DONE; q=0, phase_idx=0, rounds_left=0, busy=0.
  - Otherwise: rounds_left decrements and RUN continues with no gap cycle.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE.
- start while in RUN or DONE is ignored. rounds and dir changes mid-run have no effect.
- Timing: start sampled at edge k gives q=0 and busy=1 after edge k, and the first advance after edge k+1. One forward round (N=4) presents 8 codes over 8 cycles, then DONE.
- Invariant: q is always a legal Johnson code, i.e. a contiguous run of ones anchored at one end, or all-zero.
- Invariant: phase_idx equals the popcount-based position of q:
  - phase_idx = k for a run of k ones anchored at q[0].
  - phase_idx = 2N-k for a run of k ones anchored at q[N-1] (the all-ones code is phase N).
  - Verification checks this every cycle.
- All outputs are registered.

Decomposition:
- Package johnson_seq_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the DIR_FWD/DIR_REV constants;
  - a function that returns the legal phase index for a given q, used by the bench checker.
- Sub-module johnson_core holds the N-bit ring with ports clock, reset, en, clr, dir and q. It advances when en=1 and clears when clr=1 (clr wins).
- johnson_seq_ctrl holds the FSM, the phase counter and the round counter.

Test Plan:
- Reset 2 cycles, then start=1 for 1 cycle with rounds=1, dir=1 -> q = 0000,0001,0011,0111,1111,1110,1100,1000, then 0000 with done=1 for one cycle; busy high for exactly 8 cycles.
- rounds=3, dir=1 -> 24 cycles of busy; rounds_left steps 3 -> 2 -> 1 at each return of q to 0000; single done pulse; no idle gap between rounds.
- rounds=1, dir=0 -> q = 0000,1000,1100,1110,1111,0111,0011,0001 with phase_idx 0,7,6,5,4,3,2,1, then done.
- Forward run, hold=1 for 3 cycles at q=0111 -> q and phase_idx=3 frozen for 3 cycles; completion is delayed by exactly 3 cycles.
- stop=1 asserted with hold=1 at q=1110 -> next cycle q=0000, busy=0, no done. Separately, reset=1 mid-run -> all outputs return to reset values on the next edge.
- start with rounds=0 -> done pulse one cycle later and busy never asserts. start re-asserted during RUN -> ignored, and the sequence is unchanged.

Source files
------------

// File: rtl/johnson_seq_pkg.sv
// Shared types and helpers for the Johnson-ring sequencer.
//   state_e   : controller states (IDLE, RUN, DONE)
//   DIR_FWD   : shift left, q[0] takes ~q[N-1]
//   DIR_REV   : shift right, q[N-1] takes ~q[0]
//   phase_of  : legal phase index for a ring code, -1 if the code is illegal
package johnson_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // A run of k ones anchored at bit 0 is phase k; a run of k ones anchored
  // at bit n-1 is phase 2n-k. The all-ones code matches the first form (phase n).
  function automatic int phase_of(input logic [31:0] code, input int n);
    int          k;
    logic [31:0] low_run;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      if (code[i]) k++;
    end
    if (k == 0) return 0;
    low_run = (32'd1 << k) - 32'd1;
    if (code == low_run) return k;
    if (code == (low_run << (n - k))) return 2 * n - k;
    return -1;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// Bare N-bit Johnson (twisted-ring) shift register.
//   clock : rising-edge clock
//   reset : synchronous active-high reset, ring to all-zero
//   en    : advance one step in direction dir
//   clr   : force the ring to all-zero (wins over en)
//   dir   : DIR_FWD shifts left, DIR_REV shifts right
//   q     : registered ring value
module johnson_core
  import johnson_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic         dir,
  output logic [N-1:0] q
);

  logic [N-1:0] ring_q;
  logic [N-1:0] ring_d;

  always_comb begin
    // NOTE: default assigned first so every path drives ring_d and no latch is inferred.
    ring_d = ring_q;
    if (clr) begin
      ring_d = '0;
    end else if (en) begin
      if (dir == DIR_FWD) ring_d = {ring_q[N-2:0], ~ring_q[N-1]};
      else                ring_d = {~ring_q[0], ring_q[N-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking so every flop updates from the values present before the edge.
    if (reset) ring_q <= '0;
    else       ring_q <= ring_d;
  end

  assign q = ring_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Sequencer that runs a Johnson ring for a programmed number of full rounds
// and stops at the all-zero code.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : begin a run (IDLE only); rounds and dir sampled with it
//   rounds       : number of full 2N-state rounds (0 gives an immediate done)
//   dir          : 1 forward, 0 reverse
//   hold         : freeze ring and counters while running
//   stop         : abort the run (beats hold), no done pulse
//   q            : ring value
//   phase_idx    : position of q in the 2N-state sequence
//   busy         : high while running
//   done         : one-cycle pulse on normal completion
//   rounds_left  : rounds remaining, including the current one
module johnson_seq_ctrl
  import johnson_seq_pkg::*;
#(
  parameter int N  = 4,
  parameter int RW = 8,
  parameter int PW = $clog2(2 * N)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] rounds,
  input  logic          dir,
  input  logic          hold,
  input  logic          stop,
  output logic [N-1:0]  q,
  output logic [PW-1:0] phase_idx,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] rounds_left
);

  localparam logic [PW-1:0] PHASE_LAST = PW'(2 * N - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d, phase_step;
  logic [RW-1:0] rounds_left_q, rounds_left_d;
  logic          dir_q, dir_d;
  logic          busy_q, done_q;
  logic          core_en, core_clr;
  logic          wrap;

  johnson_core #(.N(N)) u_core (
    .clock (clock),
    .reset (reset),
    .en    (core_en),
    .clr   (core_clr),
    .dir   (dir_q),
    .q     (q)
  );

  // Phase after one step in the latched direction; the ring returns to
  // all-zero exactly when this wraps to 0, which marks the round boundary.
  always_comb begin
    if (dir_q == DIR_REV) phase_step = (phase_q == '0) ? PHASE_LAST : phase_q - PW'(1);
    else                  phase_step = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
  end

  assign wrap = (phase_step == '0);

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    rounds_left_d = rounds_left_q;
    dir_d         = dir_q;
    core_en       = 1'b0;
    core_clr      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          core_clr = 1'b1;
          phase_d  = '0;
          if (rounds != '0) begin
            state_d       = ST_RUN;
            rounds_left_d = rounds;
            dir_d         = dir;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d       = ST_IDLE;
          core_clr      = 1'b1;
          phase_d       = '0;
          rounds_left_d = '0;
        end else if (!hold) begin
          core_en = 1'b1;
          phase_d = phase_step;
          if (wrap) begin
            // The final step itself lands the ring on all-zero, so no clear is needed.
            if (rounds_left_q == RW'(1)) begin
              state_d       = ST_DONE;
              rounds_left_d = '0;
            end else begin
              rounds_left_d = rounds_left_q - RW'(1);
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      phase_q       <= '0;
      rounds_left_q <= '0;
      dir_q         <= DIR_FWD;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      rounds_left_q <= rounds_left_d;
      dir_q         <= dir_d;
      busy_q        <= (state_d == ST_RUN);
      done_q        <= (state_d == ST_DONE);
    end
  end

  assign phase_idx   = phase_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign rounds_left = rounds_left_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl: a step-count model checked every
// cycle, plus directed runs with hand-computed literal expectations.
module tb_johnson_seq_ctrl;
  import johnson_seq_pkg::*;

  localparam int N  = 4;
  localparam int RW = 8;
  localparam int PW = 3;

  logic          clock;
  logic          reset;
  logic          start;
  logic [RW-1:0] rounds;
  logic          dir;
  logic          hold;
  logic          stop;
  logic [N-1:0]  q;
  logic [PW-1:0] phase_idx;
  logic          busy;
  logic          done;
  logic [RW-1:0] rounds_left;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  johnson_seq_ctrl #(.N(N), .RW(RW)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .rounds      (rounds),
    .dir         (dir),
    .hold        (hold),
    .stop        (stop),
    .q           (q),
    .phase_idx   (phase_idx),
    .busy        (busy),
    .done        (done),
    .rounds_left (rounds_left)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: total steps taken in the run --------
  bit m_run, m_done, m_dir;
  int m_steps, m_rounds;

  always @(posedge clock) begin
    if (reset) begin
      m_run = 0; m_done = 0; m_dir = 1; m_steps = 0; m_rounds = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_run) begin
      if (stop) begin
        m_run = 0; m_steps = 0; m_rounds = 0;
      end else if (!hold) begin
        m_steps++;
        if (m_steps == m_rounds * 2 * N) begin
          m_run = 0; m_done = 1; m_steps = 0; m_rounds = 0;
        end
      end
    end else if (start) begin
      if (rounds != 0) begin
        m_run = 1; m_rounds = int'(rounds); m_steps = 0; m_dir = dir;
      end else begin
        m_done = 1;
      end
    end
  end

  function automatic int exp_phase();
    int s;
    s = m_steps % (2 * N);
    if (!m_run) return 0;
    if (m_dir) return s;
    return (s == 0) ? 0 : 2 * N - s;
  endfunction

  // Code for a phase: low p ones up to phase N, then (2N-p) ones at the top.
  function automatic int code_of(input int p);
    int ones;
    if (p <= N) return (1 << p) - 1;
    ones = 2 * N - p;
    return ((1 << ones) - 1) << (N - ones);
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      check("model_q",           32'(q),           32'(code_of(exp_phase())));
      check("model_phase",       32'(phase_idx),   32'(exp_phase()));
      check("model_busy",        32'(busy),        32'(m_run));
      check("model_done",        32'(done),        32'(m_done));
      check("model_rounds_left", 32'(rounds_left),
            32'(m_run ? m_rounds - m_steps / (2 * N) : 0));
      check("inv_phase",         32'(phase_idx),   32'(phase_of(32'(q), N)));
    end
  end

  // ---------------- directed stimulus --------------------------------------
  logic [3:0] fwd_q [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};
  logic [3:0] rev_q [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                            4'b1111, 4'b0111, 4'b0011, 4'b0001};
  logic [2:0] rev_p [8] = '{3'd0, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1};

  // Leaves the bench at the negedge after the start edge (first busy cycle).
  task automatic pulse_start(input int r, input logic d);
    start = 1'b1; rounds = RW'(r); dir = d;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Counts busy cycles until done, then checks done drops after one cycle.
  task automatic wait_done(output int busy_n, output int done_n);
    busy_n = 0; done_n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        break;
      end
    end
    check("done_seen", 32'(done_n), 32'd1);
    @(negedge clock);
    check("done_single", 32'(done), 32'd0);
  endtask

  initial begin
    int cnt, b, d;
    reset = 1'b1; start = 1'b0; rounds = '0; dir = 1'b1; hold = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clock);
    chk_en = 1;
    reset  = 1'b0;
    check("rst_q", 32'(q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rounds_left", 32'(rounds_left), 32'd0);
    @(negedge clock);

    // One forward round: eight codes, then done.
    pulse_start(1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check("fwd1_q", 32'(q), 32'(fwd_q[i]));
      check("fwd1_busy", 32'(busy), 32'd1);
      @(negedge clock);
    end
    check("fwd1_done", 32'(done), 32'd1);
    check("fwd1_idle_q", 32'(q), 32'd0);
    check("fwd1_busy_off", 32'(busy), 32'd0);
    @(negedge clock);
    check("fwd1_done_off", 32'(done), 32'd0);

    // Three rounds back to back.
    @(negedge clock);
    pulse_start(3, 1'b1);
    check("r3_left_start", 32'(rounds_left), 32'd3);
    cnt = 1;
    repeat (8) begin @(negedge clock); if (busy) cnt++; end
    check("r3_left_second", 32'(rounds_left), 32'd2);
    check("r3_no_gap", 32'(busy), 32'd1);
    wait_done(b, d);
    check("r3_busy_cycles", 32'(cnt + b), 32'd24);

    // One reverse round.
    @(negedge clock);
    pulse_start(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      check("rev_q", 32'(q), 32'(rev_q[i]));
      check("rev_phase", 32'(phase_idx), 32'(rev_p[i]));
      @(negedge clock);
    end
    check("rev_done", 32'(done), 32'd1);

    // Hold for three cycles at 0111.
    repeat (2) @(negedge clock);
    pulse_start(1, 1'b1);
    cnt = 1;
    repeat (3) begin @(negedge clock); if (busy) cnt++; end
    check("hold_at", 32'(q), 32'b0111);
    hold = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (busy) cnt++;
      check("hold_q", 32'(q), 32'b0111);
      check("hold_phase", 32'(phase_idx), 32'd3);
    end
    hold = 1'b0;
    wait_done(b, d);
    check("hold_busy_cycles", 32'(cnt + b), 32'd11);

    // stop together with hold at 1110.
    @(negedge clock);
    pulse_start(2, 1'b1);
    repeat (5) @(negedge clock);
    check("stop_at", 32'(q), 32'b1110);
    hold = 1'b1; stop = 1'b1;
    @(negedge clock);
    hold = 1'b0; stop = 1'b0;
    check("stop_q", 32'(q), 32'd0);
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_done", 32'(done), 32'd0);
    check("stop_left", 32'(rounds_left), 32'd0);
    @(negedge clock);
    check("stop_no_done", 32'(done), 32'd0);

    // Reset mid-run.
    pulse_start(2, 1'b0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("mrst_q", 32'(q), 32'd0);
    check("mrst_phase", 32'(phase_idx), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_left", 32'(rounds_left), 32'd0);
    @(negedge clock);
    check("mrst_no_done", 32'(done), 32'd0);

    // rounds == 0: immediate done, never busy.
    pulse_start(0, 1'b1);
    check("r0_done", 32'(done), 32'd1);
    check("r0_busy", 32'(busy), 32'd0);
    @(negedge clock);
    check("r0_done_off", 32'(done), 32'd0);
    check("r0_busy_off", 32'(busy), 32'd0);

    // start re-asserted mid-run is ignored.
    @(negedge clock);
    pulse_start(1, 1'b1);
    cnt = 1;
    repeat (2) begin @(negedge clock); if (busy) cnt++; end
    start = 1'b1; rounds = RW'(5); dir = 1'b0;
    @(negedge clock);
    if (busy) cnt++;
    start = 1'b0;
    check("restart_q", 32'(q), 32'b0111);
    check("restart_left", 32'(rounds_left), 32'd1);
    wait_done(b, d);
    check("restart_busy_cycles", 32'(cnt + b), 32'd8);

    repeat (2) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
